// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the RV64I/Zba pipeline.
// Retires one instruction per handshake. Loads wait for the data-memory
// response, then have their data aligned and extended. The stage drives a
// registered one-cycle register-file write and raises a sticky halt on ecall.
// Optional feature macro: WB_INSTRET_EN enables the 64-bit retired-instruction
// counter on instret. Without it, instret is tied to zero.
module wb_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd_addr,
    input  logic            in_reg_wen,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    input  logic [2:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic            in_ecall,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_data,
    input  logic            dmem_rsp_err,
    output logic [4:0]      rd_addr_wb,
    output logic [XLEN-1:0] rd_data_wb,
    output logic            rd_wen_wb,
    output logic            load_fault,
    output logic            halt,
    output logic [XLEN-1:0] instret
);

    typedef enum logic {IDLE, WAIT_RSP} state_t;

    state_t      state;
    logic [4:0]  ld_rd;
    logic        ld_wen;
    logic [2:0]  ld_funct3;
    logic [2:0]  ld_off;
    logic        accept;
    logic        rsp_take;
    logic        ld_bad;

    assign in_ready = (state == IDLE) && !halt;
    assign accept   = in_valid && in_ready;
    assign rsp_take = (state == WAIT_RSP) && dmem_rsp_valid;

    // Flags a load that must not touch memory: misaligned for its width, or funct3=111.
    always_comb begin
        ld_bad = 1'b0;
        case (in_funct3)
            3'b001, 3'b101: ld_bad = in_addr_lo[0];
            3'b010, 3'b110: ld_bad = (in_addr_lo[1:0] != 2'b00);
            3'b011:         ld_bad = (in_addr_lo != 3'b000);
            3'b111:         ld_bad = 1'b1;
            default:        ld_bad = 1'b0;
        endcase
    end

    // Picks the addressed byte/half/word out of the doubleword and extends it.
    function automatic logic [63:0] extract(input logic [2:0]  f3,
                                            input logic [2:0]  off,
                                            input logic [63:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        b = d[{off, 3'b000} +: 8];
        h = d[{off[2:1], 4'b0000} +: 16];
        w = d[{off[2], 5'b00000} +: 32];
        case (f3)
            3'b000:  extract = {{56{b[7]}}, b};
            3'b100:  extract = {56'd0, b};
            3'b001:  extract = {{48{h[15]}}, h};
            3'b101:  extract = {48'd0, h};
            3'b010:  extract = {{32{w[31]}}, w};
            3'b110:  extract = {32'd0, w};
            default: extract = d;
        endcase
    endfunction

    // Handshake FSM plus the registered write, fault pulse and sticky halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_addr_wb <= '0;
            rd_data_wb <= '0;
            rd_wen_wb  <= 1'b0;
            load_fault <= 1'b0;
            halt       <= 1'b0;
            ld_rd      <= '0;
            ld_wen     <= 1'b0;
            ld_funct3  <= '0;
            ld_off     <= '0;
        end else begin
            rd_wen_wb  <= 1'b0;
            load_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_is_load) begin
                            ld_rd     <= in_rd_addr;
                            ld_wen    <= in_reg_wen;
                            ld_funct3 <= in_funct3;
                            ld_off    <= in_addr_lo;
                            if (ld_bad) begin
                                load_fault <= 1'b1;
                            end else begin
                                state <= WAIT_RSP;
                            end
                        end else begin
                            rd_wen_wb  <= in_reg_wen && (in_rd_addr != 5'd0);
                            rd_addr_wb <= in_rd_addr;
                            rd_data_wb <= in_alu_result;
                            if (in_ecall) begin
                                halt <= 1'b1;
                            end
                        end
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        state <= IDLE;
                        if (dmem_rsp_err) begin
                            load_fault <= 1'b1;
                        end else begin
                            rd_wen_wb  <= ld_wen && (ld_rd != 5'd0);
                            rd_addr_wb <= ld_rd;
                            rd_data_wb <= extract(ld_funct3, ld_off, dmem_rsp_data);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_INSTRET_EN
    // Counts ALU/ecall retires and successful load writes; faulted loads are not retired.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
        end else if ((accept && !in_is_load) || (rsp_take && !dmem_rsp_err)) begin
            instret <= instret + XLEN'(1);
        end
    end
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed bench for wb_stage with a transaction-level model
// compared on every falling edge, plus literal expectations per scenario.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd_addr;
    logic        in_reg_wen;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [2:0]  in_addr_lo;
    logic [63:0] in_alu_result;
    logic        in_ecall;
    logic        dmem_rsp_valid;
    logic [63:0] dmem_rsp_data;
    logic        dmem_rsp_err;
    logic [4:0]  rd_addr_wb;
    logic [63:0] rd_data_wb;
    logic        rd_wen_wb;
    logic        load_fault;
    logic        halt;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;

    wb_stage #(.XLEN(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd_addr     (in_rd_addr),
        .in_reg_wen     (in_reg_wen),
        .in_is_load     (in_is_load),
        .in_funct3      (in_funct3),
        .in_addr_lo     (in_addr_lo),
        .in_alu_result  (in_alu_result),
        .in_ecall       (in_ecall),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_data  (dmem_rsp_data),
        .dmem_rsp_err   (dmem_rsp_err),
        .rd_addr_wb     (rd_addr_wb),
        .rd_data_wb     (rd_data_wb),
        .rd_wen_wb      (rd_wen_wb),
        .load_fault     (load_fault),
        .halt           (halt),
        .instret        (instret)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: what the architecture says should be visible after each edge.
    logic        model_live = 1'b0;
    logic        m_wait, m_halt, m_wen, m_fault;
    logic [4:0]  m_addr;
    logic [63:0] m_data, m_cnt;
    logic [4:0]  p_rd;
    logic        p_wen;
    logic [2:0]  p_f3, p_lo;

    // A load is legal when funct3 is not 111 and the address is a multiple of its size.
    function automatic logic load_ok(input logic [2:0] f3, input logic [2:0] lo);
        int size;
        size = 1 << f3[1:0];
        return (f3 != 3'b111) && ((int'(lo) % size) == 0);
    endfunction

    // Shift the addressed bytes down, mask to size, extend by the sign bit unless unsigned.
    function automatic logic [63:0] load_value(input logic [2:0] f3, input logic [2:0] lo,
                                               input logic [63:0] d);
        int size;
        logic [63:0] mask, v;
        size = 1 << f3[1:0];
        mask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
        v = (d >> (8 * int'(lo))) & mask;
        if (!f3[2] && size < 8 && v[8 * size - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model updated at every rising edge from the inputs present at that edge.
    always @(posedge clk) begin
        if (rst) begin
            model_live = 1'b1;
            m_wait = 0; m_halt = 0; m_wen = 0; m_fault = 0;
            m_addr = 0; m_data = 0; m_cnt = 0;
        end else if (model_live) begin
            m_wen = 0;
            m_fault = 0;
            if (m_wait) begin
                if (dmem_rsp_valid) begin
                    m_wait = 0;
                    if (dmem_rsp_err) m_fault = 1;
                    else begin
                        m_addr = p_rd;
                        m_data = load_value(p_f3, p_lo, dmem_rsp_data);
                        m_wen  = p_wen && (p_rd != 0);
                        m_cnt  = m_cnt + 1;
                    end
                end
            end else if (in_valid && !m_halt) begin
                if (in_is_load) begin
                    if (load_ok(in_funct3, in_addr_lo)) begin
                        m_wait = 1;
                        p_rd = in_rd_addr; p_wen = in_reg_wen;
                        p_f3 = in_funct3;  p_lo = in_addr_lo;
                    end else m_fault = 1;
                end else begin
                    m_addr = in_rd_addr;
                    m_data = in_alu_result;
                    m_wen  = in_reg_wen && (in_rd_addr != 0);
                    if (in_ecall) m_halt = 1;
                    m_cnt = m_cnt + 1;
                end
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge once reset has been seen.
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("m_rd_wen", {63'd0, rd_wen_wb}, {63'd0, m_wen});
            checkOutput("m_fault", {63'd0, load_fault}, {63'd0, m_fault});
            checkOutput("m_halt", {63'd0, halt}, {63'd0, m_halt});
            checkOutput("m_ready", {63'd0, in_ready}, {63'd0, (!m_wait && !m_halt)});
`ifdef WB_INSTRET_EN
            checkOutput("m_instret", instret, m_cnt);
`else
            checkOutput("m_instret", instret, 64'd0);
`endif
            if (m_wen) begin
                checkOutput("m_rd_addr", {59'd0, rd_addr_wb}, {59'd0, m_addr});
                checkOutput("m_rd_data", rd_data_wb, m_data);
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic wen,
                                 input logic ld, input logic [2:0] f3, input logic [2:0] lo,
                                 input logic [63:0] alu, input logic ec);
        in_valid = v; in_rd_addr = rd; in_reg_wen = wen; in_is_load = ld;
        in_funct3 = f3; in_addr_lo = lo; in_alu_result = alu; in_ecall = ec;
    endtask

    task automatic clearInputs();
        applyStimulus(0, 0, 0, 0, 0, 0, 64'd0, 0);
        dmem_rsp_valid = 0; dmem_rsp_data = 64'd0; dmem_rsp_err = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue a load to rd=10, wait the given cycles, then deliver one response.
    task automatic doLoad(input logic [2:0] f3, input logic [2:0] lo, input logic [63:0] data,
                          input int waits, input logic err, input logic ec);
        applyStimulus(1, 5'd10, 1, 1, f3, lo, 64'd0, ec);
        cycle();
        clearInputs();
        checkOutput("ld_busy_ready", {63'd0, in_ready}, 64'd0);
        for (int w = 0; w < waits; w++) begin
            cycle();
            checkOutput("ld_wait_ready", {63'd0, in_ready}, 64'd0);
        end
        dmem_rsp_valid = 1; dmem_rsp_data = data; dmem_rsp_err = err;
        cycle();
        clearInputs();
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [2:0]  lo;
        logic [63:0] data;
        int          waits;
        logic [63:0] exp;
    } load_vec_t;

    load_vec_t vecs[8];

    initial begin
        vecs[0] = '{3'b000, 3'd3, 64'h0000_0000_8000_0000, 2, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1] = '{3'b100, 3'd3, 64'h0000_0000_8000_0000, 2, 64'h0000_0000_0000_0080};
        vecs[2] = '{3'b001, 3'd6, 64'h8001_2233_4455_6677, 0, 64'hFFFF_FFFF_FFFF_8001};
        vecs[3] = '{3'b101, 3'd2, 64'h1122_3344_F00D_5566, 1, 64'h0000_0000_0000_F00D};
        vecs[4] = '{3'b010, 3'd4, 64'h8765_4321_0000_0000, 1, 64'hFFFF_FFFF_8765_4321};
        vecs[5] = '{3'b110, 3'd0, 64'hAAAA_AAAA_9ABC_DEF0, 0, 64'h0000_0000_9ABC_DEF0};
        vecs[6] = '{3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 3, 64'h0123_4567_89AB_CDEF};
        vecs[7] = '{3'b000, 3'd0, 64'hFFFF_FFFF_FFFF_FF7F, 1, 64'h0000_0000_0000_007F};

        rst = 1;
        clearInputs();
        cycle();
        cycle();
        checkOutput("rst_wen", {63'd0, rd_wen_wb}, 64'd0);
        checkOutput("rst_fault", {63'd0, load_fault}, 64'd0);
        checkOutput("rst_halt", {63'd0, halt}, 64'd0);
        checkOutput("rst_addr", {59'd0, rd_addr_wb}, 64'd0);
        checkOutput("rst_data", rd_data_wb, 64'd0);
        checkOutput("rst_instret", instret, 64'd0);
        rst = 0;
        checkOutput("rst_ready", {63'd0, in_ready}, 64'd1);

        $display("[TB] ALU retire");
        applyStimulus(1, 5'd5, 1, 0, 0, 0, 64'h1234, 0);
        cycle();
        clearInputs();
        checkOutput("alu_wen", {63'd0, rd_wen_wb}, 64'd1);
        checkOutput("alu_addr", {59'd0, rd_addr_wb}, 64'd5);
        checkOutput("alu_data", rd_data_wb, 64'h1234);
        cycle();
        checkOutput("alu_wen_drop", {63'd0, rd_wen_wb}, 64'd0);

        $display("[TB] x0 suppression");
        applyStimulus(1, 5'd0, 1, 0, 0, 0, 64'hDEAD, 0);
        cycle();
        clearInputs();
        checkOutput("x0_wen", {63'd0, rd_wen_wb}, 64'd0);

        $display("[TB] load extraction table");
        foreach (vecs[i]) begin
            doLoad(vecs[i].f3, vecs[i].lo, vecs[i].data, vecs[i].waits, 0, 0);
            checkOutput("ld_wen", {63'd0, rd_wen_wb}, 64'd1);
            checkOutput("ld_addr", {59'd0, rd_addr_wb}, 64'd10);
            checkOutput("ld_data", rd_data_wb, vecs[i].exp);
            checkOutput("ld_ready_back", {63'd0, in_ready}, 64'd1);
        end

        $display("[TB] misaligned and illegal loads");
        applyStimulus(1, 5'd4, 1, 1, 3'b010, 3'd2, 64'd0, 0);
        cycle();
        clearInputs();
        checkOutput("mis_fault", {63'd0, load_fault}, 64'd1);
        checkOutput("mis_wen", {63'd0, rd_wen_wb}, 64'd0);
        checkOutput("mis_ready", {63'd0, in_ready}, 64'd1);
        cycle();
        checkOutput("mis_fault_drop", {63'd0, load_fault}, 64'd0);
        applyStimulus(1, 5'd4, 1, 1, 3'b111, 3'd0, 64'd0, 0);
        cycle();
        clearInputs();
        checkOutput("ill_fault", {63'd0, load_fault}, 64'd1);

        $display("[TB] bus error on LD");
        doLoad(3'b011, 3'd0, 64'h5555_5555_5555_5555, 1, 1, 0);
        checkOutput("err_fault", {63'd0, load_fault}, 64'd1);
        checkOutput("err_wen", {63'd0, rd_wen_wb}, 64'd0);

        $display("[TB] stray response in IDLE, ecall on a load");
        dmem_rsp_valid = 1; dmem_rsp_data = 64'hFFFF;
        cycle();
        clearInputs();
        checkOutput("stray_wen", {63'd0, rd_wen_wb}, 64'd0);
        doLoad(3'b011, 3'd0, 64'h42, 0, 0, 1);
        checkOutput("ldecall_halt", {63'd0, halt}, 64'd0);
        checkOutput("ldecall_data", rd_data_wb, 64'h42);

        $display("[TB] ecall halt");
        applyStimulus(1, 5'd0, 0, 0, 0, 0, 64'd0, 1);
        cycle();
        clearInputs();
        checkOutput("ecall_halt", {63'd0, halt}, 64'd1);
        checkOutput("ecall_ready", {63'd0, in_ready}, 64'd0);
        applyStimulus(1, 5'd6, 1, 0, 0, 0, 64'h99, 0);
        cycle();
        clearInputs();
        checkOutput("halted_wen", {63'd0, rd_wen_wb}, 64'd0);
        checkOutput("halted_ready", {63'd0, in_ready}, 64'd0);
        rst = 1;
        cycle();
        rst = 0;
        checkOutput("unhalt", {63'd0, halt}, 64'd0);
        checkOutput("unhalt_ready", {63'd0, in_ready}, 64'd1);

        $display("[TB] reset during WAIT_RSP");
        applyStimulus(1, 5'd8, 1, 1, 3'b011, 3'd0, 64'd0, 0);
        cycle();
        clearInputs();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        dmem_rsp_valid = 1; dmem_rsp_data = 64'h77;
        cycle();
        clearInputs();
        checkOutput("rstld_wen", {63'd0, rd_wen_wb}, 64'd0);
        checkOutput("rstld_ready", {63'd0, in_ready}, 64'd1);

        $display("[TB] back-to-back ALU and instret");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 5'(i + 1), 1, 0, 0, 0, 64'h100 + 64'(i), 0);
            cycle();
            checkOutput("b2b_wen", {63'd0, rd_wen_wb}, 64'd1);
            checkOutput("b2b_data", rd_data_wb, 64'h100 + 64'(i));
        end
        clearInputs();
        doLoad(3'b011, 3'd0, 64'h1, 1, 0, 0);
`ifdef WB_INSTRET_EN
        checkOutput("instret_4", instret, 64'd4);
`else
        checkOutput("instret_off", instret, 64'd0);
`endif
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
